// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO bypass dispatcher: info-word width,
// info-word type and statistics counter width.
package pifo_pkg;

   localparam int PIFO_INFO_WIDTH = 32;
   localparam int CNT_WIDTH       = 16;

   typedef logic [PIFO_INFO_WIDTH-1:0] pifo_info_t;

endpackage : pifo_pkg

// File: rtl/pifo_sync_fifo.sv
// Single-clock FIFO with registered show-ahead output for the PIFO enqueue path.
// A full FIFO still accepts a push in the same cycle as a pop.
module pifo_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign valid   = (count_q != '0);
   assign full    = (count_q == FULL_CNT);
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = valid ? mem_q[rd_ptr_q] : '0;
   assign count    = count_q;

endmodule : pifo_sync_fifo

// File: rtl/pifo_bypass_dispatcher.sv
// Steers bypass-checker results to a one-entry bypass register or the PIFO enqueue FIFO.
// Define PIFO_DISPATCH_STATS_EN to build the saturating stat_* counters.
module pifo_bypass_dispatcher #(
   parameter int PIFO_INFO_WIDTH = pifo_pkg::PIFO_INFO_WIDTH,
   parameter int FIFO_DEPTH      = 8,
   parameter int CNT_WIDTH       = pifo_pkg::CNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_axis_valid,
   input  logic [PIFO_INFO_WIDTH-1:0] s_axis_pifo_info,
   input  logic                       s_axis_bypass_en,
   output logic                       m_axis_bypass_valid,
   output logic [PIFO_INFO_WIDTH-1:0] m_axis_bypass_info,
   input  logic                       m_axis_bypass_ready,
   output logic                       m_axis_enq_valid,
   output logic [PIFO_INFO_WIDTH-1:0] m_axis_enq_info,
   input  logic                       m_axis_enq_ready,
   output logic [CNT_WIDTH-1:0]       stat_bypass_cnt,
   output logic [CNT_WIDTH-1:0]       stat_demote_cnt,
   output logic [CNT_WIDTH-1:0]       stat_drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic                       byp_occ_q, byp_occ_d;
   logic [PIFO_INFO_WIDTH-1:0] byp_info_q;
   logic                       byp_drain, byp_load;
   logic                       fifo_push, fifo_valid, fifo_full, enq_pop;
   logic [AW:0]                fifo_count;
   logic                       unused_fifo_count;

   // A bypass word may load while the current one drains in the same cycle.
   assign byp_drain = byp_occ_q & m_axis_bypass_ready;
   assign byp_load  = s_axis_valid & s_axis_bypass_en & (~byp_occ_q | byp_drain);
   assign fifo_push = s_axis_valid & ~byp_load;
   assign enq_pop   = fifo_valid & m_axis_enq_ready;
   assign byp_occ_d = byp_load | (byp_occ_q & ~byp_drain);

   always_ff @(posedge clk) begin
      if (rst) byp_occ_q <= 1'b0;
      else     byp_occ_q <= byp_occ_d;
   end

   always_ff @(posedge clk) begin
      if (byp_load) byp_info_q <= s_axis_pifo_info;
   end

   assign m_axis_bypass_valid = byp_occ_q;
   assign m_axis_bypass_info  = byp_occ_q ? byp_info_q : '0;

   pifo_sync_fifo #(
      .WIDTH (PIFO_INFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (s_axis_pifo_info),
      .pop       (m_axis_enq_ready),
      .pop_data  (m_axis_enq_info),
      .valid     (fifo_valid),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign m_axis_enq_valid  = fifo_valid;
   assign unused_fifo_count = ^fifo_count;

`ifdef PIFO_DISPATCH_STATS_EN
   logic                 byp_demote, enq_drop;
   logic [CNT_WIDTH-1:0] bypass_cnt_q, demote_cnt_q, drop_cnt_q;

   assign byp_demote = s_axis_valid & s_axis_bypass_en & ~byp_load;
   assign enq_drop   = fifo_push & fifo_full & ~enq_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         bypass_cnt_q <= '0;
         demote_cnt_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         if (byp_drain  && bypass_cnt_q != '1) bypass_cnt_q <= bypass_cnt_q + CNT_WIDTH'(1);
         if (byp_demote && demote_cnt_q != '1) demote_cnt_q <= demote_cnt_q + CNT_WIDTH'(1);
         if (enq_drop   && drop_cnt_q   != '1) drop_cnt_q   <= drop_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign stat_bypass_cnt = bypass_cnt_q;
   assign stat_demote_cnt = demote_cnt_q;
   assign stat_drop_cnt   = drop_cnt_q;
`else
   assign stat_bypass_cnt = '0;
   assign stat_demote_cnt = '0;
   assign stat_drop_cnt   = '0;
`endif

endmodule : pifo_bypass_dispatcher
